snow64_bfloat16_cast_arbiter: RTL and testbench
===============================================

SNOW64_BFLOAT16_CAST_ARBITER -- requirements
Module: snow64_bfloat16_cast_arbiter

Interface
REQ-001 Parameter WATCHDOG_CYCLES, default 16: cycles allowed in ISSUE+WAIT before the command is aborted with timeout.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  2  per-requester command valid; bit i = requester i.
REQ-006 req_ready  out  2  per-requester accept; transfer when req_valid[i] & req_ready[i].
REQ-007 req_op  in  2  per-requester op: 0 = cast-from-int, 1 = cast-to-int.
REQ-008 req_to_cast  in  128  operand; [63:0] requester 0, [127:64] requester 1; to-int uses low 16 bits as BFloat16.
REQ-009 req_int_type_size  in  4  int type size code (IntTypSz8/16/32/64); [1:0] req 0, [3:2] req 1.
REQ-010 req_type_signedness  in  2  per-requester signedness; 1 = signed.
REQ-011 rsp_valid  out  2  one-cycle one-hot response strobe to the owning requester.
REQ-012 rsp_data  out  64  result; from-int = {48'h0, BFloat16}, to-int = 64-bit integer.
REQ-013 rsp_timeout  out  1  qualifies rsp_valid; 1 = watchdog abort, rsp_data = 0.
REQ-014 unit_to_cast / unit_int_type_size / unit_type_signedness  out  64/2/1  captured command driven to both cast units.
REQ-015 cfi_start, cti_start  out  1 each  start pulses to cast-from-int and cast-to-int units.
REQ-016 cfi_data_valid, cfi_can_accept_cmd, cti_data_valid, cti_can_accept_cmd  in  1 each  unit status.
REQ-017 cfi_data  in  16  BFloat16 result; cti_data  in  64  integer result.

Function
REQ-018 States SHALL be IDLE, ISSUE, WAIT, RESPOND (2-bit encoding).
REQ-019 IDLE: round-robin grant among asserted req_valid; priority starts at the requester after last_grant.
REQ-020 req_ready SHALL be combinational: high only for the granted requester while in IDLE; at most one bit set.
REQ-021 On transfer: capture op, operand, size, signedness and owner; load watchdog counter to 0; go to ISSUE.
REQ-022 ISSUE: assert the op-selected start for exactly one cycle, only in a cycle where its can_accept_cmd = 1; then go to WAIT.
REQ-023 The unselected unit's start SHALL never assert; starts never assert outside ISSUE.
REQ-024 unit_* outputs SHALL hold the captured command from ISSUE entry through WAIT.
REQ-025 WAIT: data_valid is sampled only in WAIT. On selected data_valid = 1, capture result into rsp_data and go to RESPOND.
REQ-026 Watchdog counts each ISSUE/WAIT cycle. At count WATCHDOG_CYCLES-1 without completion: rsp_data = 0, rsp_timeout = 1, go to RESPOND.
REQ-027 Completion and watchdog expiry in the same cycle: completion wins, rsp_timeout = 0.
REQ-028 RESPOND: rsp_valid[owner] = 1 for one cycle; last_grant <= owner; go to IDLE.
REQ-029 rsp_data and rsp_timeout SHALL hold until the next RESPOND.
REQ-030 Latency with unit can_accept_cmd = 1 (from-int valid 2 cycles after start, to-int 3 cycles): transfer cycle T; start at T+1; rsp_valid at T+4 (from-int), T+5 (to-int).
REQ-031 Next transfer SHALL be no earlier than the cycle after RESPOND; one command in flight at most.
REQ-032 A requester holding req_valid without grant SHALL keep its command stable; the arbiter does not sample it.

Reset
REQ-033 On rst: state IDLE; last_grant = 1 so requester 0 wins first; watchdog counter = 0.
REQ-034 On rst: req_ready, rsp_valid, cfi_start, cti_start = 0; rsp_data = 0; rsp_timeout = 0; unit_* = 0.
REQ-035 Reset mid-operation: the in-flight command is dropped with no rsp_valid.
REQ-036 Cast units have no reset. After rst, ISSUE SHALL still wait for can_accept_cmd before starting.

Verification
REQ-037 From-int: req0, op=0, to_cast=1, IntTypSz8, unsigned; unit model returns 16'h3F80 -> rsp_valid=2'b01 at T+4, rsp_data=64'h3F80, rsp_timeout=0.
REQ-038 To-int: req1, op=1, to_cast=16'h4120, IntTypSz32, signed; unit returns 64'd10 -> rsp_valid=2'b10 at T+5, rsp_data=64'd10.
REQ-039 Fairness: both req_valid held after reset -> order req0, req1, req0, req1; req_ready never 2'b11.
REQ-040 Backpressure: cfi_can_accept_cmd low 3 cycles after transfer -> single cfi_start in the 4th ISSUE cycle; cti_start stays 0.
REQ-041 Watchdog: unit never asserts data_valid, WATCHDOG_CYCLES=16 -> rsp_valid at T+17, rsp_timeout=1, rsp_data=0.
REQ-042 Reset in WAIT: no rsp_valid; a following req0 command completes with normal latency.

Source files
------------

// File: rtl/snow64_bfloat16_cast_arbiter.sv
// snow64_bfloat16_cast_arbiter
// Two-requester round-robin front end for the BFloat16 cast units.
// One command is in flight at a time: it is captured on transfer, started on
// the op-selected unit once that unit can take it, and its result (or a
// watchdog abort) is returned to the owning requester as a one-cycle strobe.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no command in flight; round-robin grant offered via req_ready
// ISSUE   | command captured; waiting for the selected unit to accept start
// WAIT    | start issued; waiting for the selected unit's data_valid
// RESPOND | rsp_valid strobed to the owner for one cycle, then back to IDLE

module snow64_bfloat16_cast_arbiter #(
  parameter int WATCHDOG_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,

  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [1:0]    req_op,
  input  logic [127:0]  req_to_cast,
  input  logic [3:0]    req_int_type_size,
  input  logic [1:0]    req_type_signedness,

  output logic [1:0]    rsp_valid,
  output logic [63:0]   rsp_data,
  output logic          rsp_timeout,

  output logic [63:0]   unit_to_cast,
  output logic [1:0]    unit_int_type_size,
  output logic          unit_type_signedness,

  output logic          cfi_start,
  output logic          cti_start,

  input  logic          cfi_data_valid,
  input  logic          cfi_can_accept_cmd,
  input  logic          cti_data_valid,
  input  logic          cti_can_accept_cmd,
  input  logic [15:0]   cfi_data,
  input  logic [63:0]   cti_data
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  // op encoding of the captured command
  localparam logic OP_FROM_INT = 1'b0;

  localparam int             WD_W    = $clog2(WATCHDOG_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  state_t          state_q;
  state_t          state_d;

  logic            last_grant_q;
  logic            owner_q;
  logic            op_q;
  logic [WD_W-1:0] wd_cnt_q;

  logic            grant_any;
  logic            grant_idx;
  logic            transfer;

  logic            busy;
  logic            sel_can_accept;
  logic            sel_data_valid;
  logic [63:0]     sel_result;
  logic            done;
  logic            wd_expire;

  // Round-robin pick: the requester after last_grant has priority.
  always_comb begin
    grant_any = |req_valid;
    if (last_grant_q) begin
      grant_idx = req_valid[0] ? 1'b0 : 1'b1;
    end else begin
      grant_idx = req_valid[1] ? 1'b1 : 1'b0;
    end
  end

  // Accept is offered only in IDLE and only to the single granted requester.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == ST_IDLE && grant_any) begin
      req_ready = grant_idx ? 2'b10 : 2'b01;
    end
    transfer = |(req_valid & req_ready);
  end

  // Route the status/result of whichever unit the captured op selects.
  always_comb begin
    busy = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    if (op_q == OP_FROM_INT) begin
      sel_can_accept = cfi_can_accept_cmd;
      sel_data_valid = cfi_data_valid;
      sel_result     = {48'h0, cfi_data};
    end else begin
      sel_can_accept = cti_can_accept_cmd;
      sel_data_valid = cti_data_valid;
      sel_result     = cti_data;
    end
    // data_valid is ignored outside WAIT; completion beats a same-cycle expiry
    done      = (state_q == ST_WAIT) && sel_data_valid;
    wd_expire = busy && (wd_cnt_q == WD_LAST) && !done;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (transfer) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (wd_expire) begin
          state_d = ST_RESPOND;
        end else if (sel_can_accept) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done || wd_expire) state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: start pulses and the response strobe.
  // A start is withheld in the expiry cycle so an aborted command never
  // reaches a unit that would then answer into an idle arbiter.
  always_comb begin
    cfi_start = 1'b0;
    cti_start = 1'b0;
    rsp_valid = 2'b00;
    if (state_q == ST_ISSUE && sel_can_accept && !wd_expire) begin
      if (op_q == OP_FROM_INT) begin
        cfi_start = 1'b1;
      end else begin
        cti_start = 1'b1;
      end
    end
    if (state_q == ST_RESPOND) begin
      rsp_valid = owner_q ? 2'b10 : 2'b01;
    end
  end

  // Capture the granted command; unit_* stay stable until the next transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q                 <= 1'b0;
      owner_q              <= 1'b0;
      unit_to_cast         <= 64'h0;
      unit_int_type_size   <= 2'b00;
      unit_type_signedness <= 1'b0;
    end else if (transfer) begin
      op_q                 <= req_op[grant_idx];
      owner_q              <= grant_idx;
      unit_to_cast         <= grant_idx ? req_to_cast[127:64] : req_to_cast[63:0];
      unit_int_type_size   <= grant_idx ? req_int_type_size[3:2] : req_int_type_size[1:0];
      unit_type_signedness <= req_type_signedness[grant_idx];
    end
  end

  // Watchdog: cleared on transfer, advanced on every ISSUE/WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else if (transfer) begin
      wd_cnt_q <= '0;
    end else if (busy) begin
      wd_cnt_q <= wd_cnt_q + WD_ONE;
    end
  end

  // Response payload, held until the next command finishes or aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data    <= 64'h0;
      rsp_timeout <= 1'b0;
    end else if (done) begin
      rsp_data    <= sel_result;
      rsp_timeout <= 1'b0;
    end else if (wd_expire) begin
      rsp_data    <= 64'h0;
      rsp_timeout <= 1'b1;
    end
  end

  // Round-robin pointer moves to the owner when its response goes out.
  // Reset value 1 hands the first grant to requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (state_q == ST_RESPOND) begin
      last_grant_q <= owner_q;
    end
  end

endmodule

// File: tb/tb_snow64_bfloat16_cast_arbiter.sv
// Directed bench for snow64_bfloat16_cast_arbiter with behavioural cast-unit
// responders and a response scoreboard keyed on expected arrival cycle.

module tb_snow64_bfloat16_cast_arbiter;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_ready;
  logic [1:0]    req_op = '0;
  logic [127:0]  req_to_cast = '0;
  logic [3:0]    req_int_type_size = '0;
  logic [1:0]    req_type_signedness = '0;
  logic [1:0]    rsp_valid;
  logic [63:0]   rsp_data;
  logic          rsp_timeout;
  logic [63:0]   unit_to_cast;
  logic [1:0]    unit_int_type_size;
  logic          unit_type_signedness;
  logic          cfi_start, cti_start;
  logic          cfi_data_valid = 1'b0;
  logic          cfi_can_accept_cmd = 1'b1;
  logic          cti_data_valid = 1'b0;
  logic          cti_can_accept_cmd = 1'b1;
  logic [15:0]   cfi_data = '0;
  logic [63:0]   cti_data = '0;

  snow64_bfloat16_cast_arbiter #(.WATCHDOG_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_to_cast(req_to_cast), .req_int_type_size(req_int_type_size),
    .req_type_signedness(req_type_signedness),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .unit_to_cast(unit_to_cast), .unit_int_type_size(unit_int_type_size),
    .unit_type_signedness(unit_type_signedness),
    .cfi_start(cfi_start), .cti_start(cti_start),
    .cfi_data_valid(cfi_data_valid), .cfi_can_accept_cmd(cfi_can_accept_cmd),
    .cti_data_valid(cti_data_valid), .cti_can_accept_cmd(cti_can_accept_cmd),
    .cfi_data(cfi_data), .cti_data(cti_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [63:0] d;
    logic        to;
    int          c;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // cast-unit responder knobs
  int          cfi_lat = 2;
  int          cti_lat = 3;
  bit          cfi_en = 1'b1;
  bit          cti_en = 1'b1;
  logic [15:0] cfi_ret = '0;
  logic [63:0] cti_ret = '0;
  int          cfi_cnt = 0;
  int          cti_cnt = 0;
  int          n_cfi = 0;
  int          n_cti = 0;
  bit          saw_both = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cfi_start) n_cfi <= n_cfi + 1;
    if (cti_start) n_cti <= n_cti + 1;
  end

  always @(negedge clk) if (req_ready == 2'b11) saw_both <= 1'b1;

  // from-int unit: data_valid cfi_lat cycles after the start cycle
  always @(posedge clk) begin
    cfi_data_valid <= 1'b0;
    if (cfi_cnt > 0) begin
      cfi_cnt <= cfi_cnt - 1;
      if (cfi_cnt == 1) begin
        cfi_data_valid <= 1'b1;
        cfi_data       <= cfi_ret;
      end
    end
    if (cfi_start && cfi_en) cfi_cnt <= cfi_lat - 1;
  end

  // to-int unit: data_valid cti_lat cycles after the start cycle
  always @(posedge clk) begin
    cti_data_valid <= 1'b0;
    if (cti_cnt > 0) begin
      cti_cnt <= cti_cnt - 1;
      if (cti_cnt == 1) begin
        cti_data_valid <= 1'b1;
        cti_data       <= cti_ret;
      end
    end
    if (cti_start && cti_en) cti_cnt <= cti_lat - 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present one command and hold it until granted; t = transfer cycle.
  task automatic issue(input int idx, input logic op, input logic [63:0] d,
                       input logic [1:0] sz, input logic sg, output int t);
    req_op[idx]                    = op;
    req_to_cast[idx*64 +: 64]      = d;
    req_int_type_size[idx*2 +: 2]  = sz;
    req_type_signedness[idx]       = sg;
    req_valid[idx]                 = 1'b1;
    #1;
    t = -1;
    for (int n = 0; n < 40; n++) begin
      if (req_ready[idx]) begin
        t = cyc;
        break;
      end
      step();
    end
    if (t < 0) chk("issue_grant", 64'(req_ready[idx]), 64'd1);
    step();
    req_valid[idx] = 1'b0;
  endtask

  // Wait (bounded) for a response strobe and compare it with the scoreboard head.
  task automatic wait_rsp(input string tag, output int rc);
    exp_t e;
    int   n;
    n  = 0;
    rc = -1;
    while (rsp_valid == 2'b00 && n < 60) begin
      step();
      n++;
    end
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb_empty observed=%h expected=none", tag, rsp_valid);
      return;
    end
    e  = sb.pop_front();
    rc = cyc;
    chk({tag, "_valid"},   64'(rsp_valid),   64'(e.v));
    chk({tag, "_data"},    rsp_data,         e.d);
    chk({tag, "_timeout"}, 64'(rsp_timeout), 64'(e.to));
    chk({tag, "_cycle"},   64'(cyc),         64'(e.c));
    step();
    chk({tag, "_one_cycle"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_hold"},      rsp_data,       e.d);
  endtask

  initial begin
    int t, rc, n, n0, n1, last_rc, rsp_seen;
    logic [1:0] exp_g;

    // reset state
    step();
    step();
    chk("rst_ready",     64'(req_ready),   64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid),   64'd0);
    chk("rst_rsp_data",  rsp_data,         64'd0);
    chk("rst_timeout",   64'(rsp_timeout), 64'd0);
    chk("rst_unit",      {unit_to_cast[60:0], unit_int_type_size, unit_type_signedness}, 64'd0);
    chk("rst_starts",    64'({cfi_start, cti_start}), 64'd0);
    rst = 1'b0;
    step();

    // from-int, requester 0
    cfi_ret = 16'h3F80;
    issue(0, 1'b0, 64'd1, 2'd0, 1'b0, t);
    sb.push_back('{v: 2'b01, d: 64'h3F80, to: 1'b0, c: t + 4});
    chk("fi_cfi_start", 64'(cfi_start),  64'd1);
    chk("fi_cti_start", 64'(cti_start),  64'd0);
    chk("fi_ready_busy", 64'(req_ready), 64'd0);
    chk("fi_unit_cast", unit_to_cast,    64'd1);
    wait_rsp("fi", rc);

    // to-int, requester 1
    cti_ret = 64'd10;
    issue(1, 1'b1, 64'h4120, 2'd2, 1'b1, t);
    sb.push_back('{v: 2'b10, d: 64'd10, to: 1'b0, c: t + 5});
    chk("ti_cti_start", 64'(cti_start),    64'd1);
    chk("ti_cfi_start", 64'(cfi_start),    64'd0);
    chk("ti_unit_cast", unit_to_cast,      64'h4120);
    chk("ti_unit_size", 64'(unit_int_type_size),   64'd2);
    chk("ti_unit_sign", 64'(unit_type_signedness), 64'd1);
    wait_rsp("ti", rc);

    // backpressure: from-int unit busy for the first three ISSUE cycles
    n0 = n_cfi;
    n1 = n_cti;
    cfi_can_accept_cmd = 1'b0;
    issue(0, 1'b0, 64'd7, 2'd1, 1'b0, t);
    chk("bp_hold_1", 64'(cfi_start), 64'd0);
    step();
    chk("bp_hold_2", 64'(cfi_start), 64'd0);
    step();
    chk("bp_hold_3", 64'(cfi_start), 64'd0);
    step();
    cfi_can_accept_cmd = 1'b1;
    cfi_ret = 16'h40E0;
    #1;
    chk("bp_start_4th", 64'(cfi_start),  64'd1);
    chk("bp_unit_held", unit_to_cast,    64'd7);
    sb.push_back('{v: 2'b01, d: 64'h40E0, to: 1'b0, c: t + 7});
    wait_rsp("bp", rc);
    chk("bp_cfi_pulses", 64'(n_cfi - n0), 64'd1);
    chk("bp_cti_pulses", 64'(n_cti - n1), 64'd0);

    // watchdog: unit never answers
    cfi_en = 1'b0;
    issue(1, 1'b0, 64'd5, 2'd3, 1'b1, t);
    sb.push_back('{v: 2'b10, d: 64'd0, to: 1'b1, c: t + 17});
    wait_rsp("wd", rc);
    chk("wd_timeout_hold", 64'(rsp_timeout), 64'd1);
    cfi_en = 1'b1;

    // completion in the expiry cycle wins
    cfi_lat = 15;
    cfi_ret = 16'h1234;
    issue(0, 1'b0, 64'd9, 2'd0, 1'b0, t);
    sb.push_back('{v: 2'b01, d: 64'h1234, to: 1'b0, c: t + 17});
    wait_rsp("wd_race", rc);

    // completion one cycle too late is aborted
    cfi_lat = 16;
    cfi_ret = 16'h5555;
    issue(0, 1'b0, 64'd3, 2'd0, 1'b0, t);
    sb.push_back('{v: 2'b01, d: 64'd0, to: 1'b1, c: t + 17});
    wait_rsp("wd_late", rc);
    cfi_lat = 2;
    repeat (3) step();

    // reset while in WAIT drops the command
    cti_lat = 6;
    cti_ret = 64'hDEAD;
    issue(0, 1'b1, 64'h4000, 2'd2, 1'b1, t);
    step();
    rst = 1'b1;
    step();
    chk("rstw_rsp_data", rsp_data, 64'd0);
    rst = 1'b0;
    rsp_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid != 2'b00) rsp_seen++;
      step();
    end
    chk("rstw_no_rsp", 64'(rsp_seen), 64'd0);
    cti_lat = 3;
    cfi_ret = 16'h4040;
    issue(0, 1'b0, 64'd3, 2'd0, 1'b0, t);
    sb.push_back('{v: 2'b01, d: 64'h4040, to: 1'b0, c: t + 4});
    wait_rsp("rstw_next", rc);

    // fairness: both requesters held from reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    req_op = 2'b00;
    req_to_cast = {64'd22, 64'd11};
    req_valid = 2'b11;
    #1;
    last_rc = -1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 40) begin
        step();
        n++;
      end
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("fair_grant", 64'(req_ready), 64'(exp_g));
      if (k > 0) chk("fair_next_cycle", 64'(cyc), 64'(last_rc + 1));
      cfi_ret = 16'(16'h4000 + k);
      sb.push_back('{v: exp_g, d: {48'h0, cfi_ret}, to: 1'b0, c: cyc + 4});
      step();
      chk("fair_unit_cast", unit_to_cast, (k % 2 == 0) ? 64'd11 : 64'd22);
      wait_rsp("fair", last_rc);
    end
    req_valid = 2'b00;
    step();
    chk("fair_never_both", 64'(saw_both), 64'd0);
    chk("sb_drained",      64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
